// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults, frame constants and FSM state encoding
// used by both the transmit and receive sides.
package uart_pkg;
    localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
    localparam int unsigned DEF_BAUD_RATE = 115200;
    localparam int unsigned DATA_BITS     = 8;
    localparam int unsigned STOP_BITS     = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-level request/status bundle plus the serial line of the transmitter.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_pin;

    modport master (output tx_data, tx_start, input tx_busy, tx_done, tx_pin);
    modport slave  (input tx_data, tx_start, output tx_busy, tx_done, tx_pin);
endinterface

// File: rtl/uart_tx_baud_gen.sv
// baud_gen: counts 0..BAUD_DIV-1 and flags the last cycle of each bit period.
module baud_gen #(
    parameter int unsigned BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == CW'(BAUD_DIV - 1);

    always_comb cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter; one request accepted per idle period,
// start bit appears the cycle after acceptance.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
    parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus
);
    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned IW       = $clog2(DATA_BITS);

    generate
        if (BAUD_DIV < 2) begin : g_bad_div
            $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 pin_q, pin_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 last_bit;

    // Counter is held at zero while idle, so the start bit gets a full period.
    baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    assign last_bit = idx_q == IW'(DATA_BITS - 1);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        pin_d   = pin_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.tx_start) begin
                state_d = START;
                sh_d    = bus.tx_data;
                idx_d   = '0;
                pin_d   = 1'b0;
            end
            START: if (tick) begin
                state_d = DATA;
                pin_d   = sh_q[0];
            end
            // pin is registered, so the next bit is looked up one position ahead
            DATA: if (tick) begin
                state_d = last_bit ? STOP : DATA;
                sh_d    = sh_q >> 1;
                idx_d   = idx_q + 1'b1;
                pin_d   = last_bit ? 1'b1 : sh_q[1];
            end
            STOP: if (tick) begin
                state_d = IDLE;
                pin_d   = 1'b1;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            pin_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            pin_q   <= pin_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx_pin  = pin_q;
    assign bus.tx_busy = state_q != IDLE;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-level reference model checked every cycle, plus table-driven
// frames and hand-written back-to-back, mid-frame request and reset-abort sequences.
module tb_uart_tx;
    localparam int D  = 4;
    localparam int FL = 10 * D;

    typedef struct {
        logic [7:0] d;
        logic [9:0] seq;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_if bus();

    uart_tx #(.CLK_FREQ(400), .BAUD_RATE(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    logic pin_log  [0:4095];
    logic done_log [0:4095];

    // Model: ph counts cycles since acceptance (0 = no frame in flight).
    int         ph     = 0;
    logic [9:0] fr     = '0;
    logic       done_m = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic [7:0] d);
        logic ep, eb;
        rst          = r;
        bus.tx_start = s;
        bus.tx_data  = d;
        @(posedge clk);
        if (r) begin
            ph     = 0;
            done_m = 1'b0;
        end else if (ph == 0) begin
            done_m = 1'b0;
            if (s) begin
                ph = 1;
                fr = {1'b1, d, 1'b0};
            end
        end else if (ph == FL) begin
            ph     = 0;
            done_m = 1'b1;
        end else begin
            ph++;
        end
        cyc++;
        @(negedge clk);
        ep = ph > 0 ? fr[(ph - 1) / D] : 1'b1;
        eb = ph > 0;
        chk("pin",  16'(bus.tx_pin),  16'(ep));
        chk("busy", 16'(bus.tx_busy), 16'(eb));
        chk("done", 16'(bus.tx_done), 16'(done_m));
        pin_log[cyc]  = bus.tx_pin;
        done_log[cyc] = bus.tx_done;
    endtask

    function automatic logic [9:0] seq_at(input int a);
        logic [9:0] s;
        for (int j = 0; j < 10; j++) s[9 - j] = pin_log[a + 1 + j * D + D / 2];
        return s;
    endfunction

    function automatic int dones(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(done_log[i]);
        return n;
    endfunction

    vec_t vecs [5];
    int   a;
    int   idle_bad;

    initial begin
        vecs[0] = '{8'hA5, 10'b0101001011};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'h81, 10'b0100000011};
        vecs[4] = '{8'h55, 10'b0101010101};
        rst = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 8'($urandom));
            if (bus.tx_pin !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) idle_bad++;
        end
        chk("idle20", 16'(idle_bad), 16'd0);
        // table: each frame with tx_data inverted after acceptance
        foreach (vecs[k]) begin
            a = cyc;
            tick(1'b0, 1'b1, vecs[k].d);
            repeat (FL + 1) tick(1'b0, 1'b0, ~vecs[k].d);
            chk("frame_bits", 16'(seq_at(a)), 16'(vecs[k].seq));
            chk("done_at_41", 16'(done_log[a + FL + 1]), 16'd1);
            chk("done_count", 16'(dones(a + 1, a + FL + 2)), 16'd1);
        end
        // back-to-back with tx_start held high
        a = cyc;
        tick(1'b0, 1'b1, 8'h00);
        repeat (FL + 1) tick(1'b0, 1'b1, 8'hFF);
        repeat (FL + 1) tick(1'b0, 1'b0, 8'h00);
        chk("b2b_frame0", 16'(seq_at(a)), 16'(10'b0000000001));
        chk("b2b_frame1", 16'(seq_at(a + FL + 1)), 16'(10'b0111111111));
        chk("b2b_edge_gap", 16'({pin_log[a + 1], pin_log[a + FL + 1], pin_log[a + FL + 2]}), 16'(3'b010));
        chk("b2b_done0", 16'(done_log[a + FL + 1]), 16'd1);
        chk("b2b_done1", 16'(done_log[a + 2 * FL + 2]), 16'd1);
        // request mid-frame must be ignored
        a = cyc;
        tick(1'b0, 1'b1, 8'h3C);
        repeat (14) tick(1'b0, 1'b0, 8'h3C);
        tick(1'b0, 1'b1, 8'h99);
        repeat (FL + 4) tick(1'b0, 1'b0, 8'h99);
        chk("midreq_frame", 16'(seq_at(a)), 16'(10'b0001111001));
        chk("midreq_dones", 16'(dones(a + 1, cyc)), 16'd1);
        // reset during data bit 3 aborts the frame
        a = cyc;
        tick(1'b0, 1'b1, 8'h55);
        repeat (17) tick(1'b0, 1'b0, 8'h55);
        chk("pre_abort_busy", 16'(bus.tx_busy), 16'd1);
        tick(1'b1, 1'b0, 8'h55);
        chk("abort_pin", 16'(bus.tx_pin), 16'd1);
        chk("abort_busy", 16'(bus.tx_busy), 16'd0);
        repeat (45) tick(1'b0, 1'b0, 8'h00);
        chk("abort_no_done", 16'(dones(a + 1, cyc)), 16'd0);
        a = cyc;
        tick(1'b0, 1'b1, 8'h81);
        repeat (FL + 1) tick(1'b0, 1'b0, 8'h7E);
        chk("after_abort_frame", 16'(seq_at(a)), 16'(10'b0100000011));
        // request coincident with reset is ignored
        tick(1'b1, 1'b1, 8'hA5);
        chk("rst_start_busy", 16'(bus.tx_busy), 16'd0);
        tick(1'b0, 1'b0, 8'h00);
        chk("rst_start_pin", 16'(bus.tx_pin), 16'd1);
        // random traffic against the model
        for (int i = 0; i < 800; i++)
            tick(($urandom % 97) == 0, ($urandom % 5) == 0, 8'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate in bit/s.
REQ-003 SHALL derive BAUD_DIV = CLK_FREQ / BAUD_RATE (integer truncation); BAUD_DIV < 2 is a parameter error.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 tx_data  input  8  byte to send; sampled only on an accepted request.
REQ-007 tx_start  input  1  send request; accepted when tx_busy=0.
REQ-008 tx_busy  output  1  high while a frame is in progress.
REQ-009 tx_done  output  1  one-cycle pulse when a frame has completed.
REQ-010 tx_pin  output  1  serial line, idle high.

Function
REQ-011 SHALL emit 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-012 SHALL hold each bit on tx_pin for exactly BAUD_DIV clk cycles.
REQ-013 SHALL use FSM states IDLE, START, DATA, STOP.
- IDLE: leave to START on tx_start=1.
- START: leave to DATA after BAUD_DIV cycles.
- DATA: leave to STOP after 8 bit periods.
- STOP: leave to IDLE after BAUD_DIV cycles.
REQ-014 SHALL accept a request only in IDLE with tx_start=1; this is the accept cycle.
REQ-015 SHALL latch tx_data into an internal shift register on the accept cycle; later tx_data changes SHALL NOT affect the frame.
REQ-016 SHALL drive tx_pin low and tx_busy high on the cycle after the accept cycle; latency from tx_start to start bit is 1 cycle.
REQ-017 SHALL ignore tx_start while tx_busy=1; no queuing, no frame corruption.
REQ-018 SHALL use a baud counter 0..BAUD_DIV-1, cleared on accept; a bit boundary occurs when the counter reaches BAUD_DIV-1.
REQ-019 SHALL use a bit index 0..7 in DATA, advanced at each bit boundary; the shift register shifts right at each data-bit boundary.
REQ-020 SHALL, after the last STOP cycle, return to IDLE: tx_busy=0, tx_pin=1, tx_done=1 for exactly that first IDLE cycle.
REQ-021 SHALL accept a tx_start present in the tx_done cycle (back-to-back frames).
REQ-022 With tx_start held high, start-bit leading edges SHALL be exactly 10*BAUD_DIV+1 cycles apart.
REQ-023 SHALL make tx_pin a registered output, glitch-free, and never X after reset.

Reset
REQ-024 rst=1 at any clock edge SHALL force state IDLE, tx_pin=1, tx_busy=0, tx_done=0, and clear the counters and shift register.
REQ-025 rst during a frame SHALL abort it: tx_pin=1 on the next cycle and no tx_done pulse for the aborted frame.
REQ-026 tx_start coincident with rst SHALL be ignored.

Structure
REQ-027 Shared package uart_pkg SHALL hold:
- default CLK_FREQ and BAUD_RATE;
- frame constants: data bits = 8, stop bits = 1;
- the FSM state encoding, also used by the receive side.
REQ-028 The baud counter MAY be a sub-module baud_gen (parameter BAUD_DIV; inputs clk, rst, clear; output tick), shared with the receiver.

Verification (bench uses BAUD_DIV=4)
REQ-029 Reset, then 20 idle cycles -> tx_pin=1, tx_busy=0, tx_done=0 throughout.
REQ-030 Single send of tx_data=0xA5 -> tx_pin sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done pulses once, 41 cycles after the accept cycle.
REQ-031 tx_start held high with data 0x00 then 0xFF -> two correct frames, start edges 41 cycles apart, tx_done pulses in both accept-coincident idle cycles.
REQ-032 Send 0x3C, then pulse tx_start with tx_data=0x99 mid-frame -> 0x99 ignored, frame bits match 0x3C, one tx_done only.
REQ-033 Send 0x55, assert rst during data bit 3 -> tx_pin=1 the next cycle, tx_busy=0, no tx_done; a following send of 0x81 transmits correctly.
